// File: rtl/dm_store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_store_buffer_if
//  Description : Request/response bundle between the MEM stage, the store
//                buffer and the data memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dm_store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  // Store request side
  logic            st_valid;
  logic [31:0]     st_addr;
  logic [31:0]     st_wd;
  logic [2:0]      st_op;
  logic            st_ready;

  // Load request side
  logic            ld_valid;
  logic [31:0]     ld_addr;
  logic [2:0]      ld_op;
  logic            ld_stall;

  // Data memory port
  logic [31:0]     dm_a;
  logic [31:0]     dm_wd;
  logic [2:0]      dm_op;
  logic            dm_we;

  // Occupancy status
  logic [c_CW-1:0] count;
  logic            empty;

  // Requester view (MEM stage plus DM observer)
  modport master (
    output st_valid, st_addr, st_wd, st_op,
    output ld_valid, ld_addr, ld_op,
    input  st_ready, ld_stall,
    input  dm_a, dm_wd, dm_op, dm_we,
    input  count, empty
  );

  // Store buffer view
  modport slave (
    input  st_valid, st_addr, st_wd, st_op,
    input  ld_valid, ld_addr, ld_op,
    output st_ready, ld_stall,
    output dm_a, dm_wd, dm_op, dm_we,
    output count, empty
  );
endinterface
`default_nettype wire

// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dm_store_buffer
//  Description : FIFO write buffer in front of the data memory. Stores are
//                queued and drained one per cycle when the DM port is free;
//                loads pass straight through unless they hit a pending store
//                word, in which case they stall until that store has drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  dm_store_buffer_if.slave bus
);

  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = c_PW + 1;

  // Entry storage
  logic [31:0]     r_addr [DEPTH];
  logic [31:0]     r_wd   [DEPTH];
  logic [2:0]      r_op   [DEPTH];

  // Queue bookkeeping
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_CW-1:0] r_count;

  logic             w_empty;
  logic             w_ready;
  logic             w_push;
  logic             w_hit;
  logic             w_drain;
  logic             w_st_same_word;
  logic [DEPTH-1:0] w_match;

  logic [31:0]      w_dm_a;
  logic [31:0]      w_dm_wd;
  logic [2:0]       w_dm_op;
  logic             w_dm_we;

  assign w_empty = (r_count == '0);
  // Readiness looks at the current count only, so a full buffer refuses a
  // store even in a cycle where it also drains.
  assign w_ready = (r_count < c_CW'(DEPTH));
  assign w_push  = bus.st_valid && w_ready;

  // Per-entry word-address compare, qualified by occupancy. An entry is live
  // when its distance from head (mod DEPTH) is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [c_PW-1:0] w_off;
    assign w_off       = c_PW'(gi) - r_head;
    assign w_match[gi] = ({1'b0, w_off} < r_count) &&
                         (r_addr[gi][31:2] == bus.ld_addr[31:2]);
  end

  // A store presented in the same cycle also counts as a hit, whether or
  // not it is accepted, so the load never overtakes it.
  assign w_st_same_word = bus.st_valid && (bus.st_addr[31:2] == bus.ld_addr[31:2]);
  assign w_hit          = bus.ld_valid && ((|w_match) || w_st_same_word);

  // Draining while stalled guarantees the blocking store eventually leaves.
  assign w_drain = !w_empty && (!bus.ld_valid || w_hit);

  // DM port mux: head entry when draining, otherwise the load passes through
  always_comb begin
    w_dm_we = 1'b0;
    w_dm_a  = bus.ld_addr;
    w_dm_op = bus.ld_op;
    w_dm_wd = '0;
    if (w_drain) begin
      w_dm_we = 1'b1;
      w_dm_a  = r_addr[r_head];
      w_dm_wd = r_wd[r_head];
      w_dm_op = r_op[r_head];
    end
  end

  // Pointer and occupancy update; reset discards pending stores
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_PW'(1);
      end
      if (w_drain) begin
        r_head <= r_head + c_PW'(1);
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload capture at the tail; payload needs no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.st_addr;
      r_wd[r_tail]   <= bus.st_wd;
      r_op[r_tail]   <= bus.st_op;
    end
  end

  assign bus.st_ready = w_ready;
  assign bus.ld_stall = w_hit;
  assign bus.dm_a     = w_dm_a;
  assign bus.dm_wd    = w_dm_wd;
  assign bus.dm_op    = w_dm_op;
  assign bus.dm_we    = w_dm_we;
  assign bus.count    = r_count;
  assign bus.empty    = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_store_buffer
//  Description : Directed self-checking bench for dm_store_buffer with a
//                small behavioural data memory on the DM port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_store_buffer;

  localparam logic [2:0] c_DM_W = 3'd0;
  localparam logic [2:0] c_DM_H = 3'd1;
  localparam logic [2:0] c_DM_B = 3'd2;

  logic clk;
  logic reset;

  int n_checks;
  int n_errors;

  dm_store_buffer_if #(.DEPTH(4)) bus ();

  dm_store_buffer #(.DEPTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DM: 256 words, combinational read, byte/half/word writes
  logic [31:0] mem [256];
  logic [31:0] dm_rd;
  logic [7:0]  w_idx;
  assign w_idx = bus.dm_a[9:2];
  assign dm_rd = mem[w_idx];

  // DM write port
  always @(posedge clk) begin
    if (bus.dm_we) begin
      case (bus.dm_op)
        c_DM_H:  mem[w_idx][bus.dm_a[1]*16 +: 16] <= bus.dm_wd[15:0];
        c_DM_B:  mem[w_idx][bus.dm_a[1:0]*8 +: 8] <= bus.dm_wd[7:0];
        default: mem[w_idx] <= bus.dm_wd;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic st_drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    bus.st_valid = v;
    bus.st_addr  = a;
    bus.st_wd    = d;
    bus.st_op    = op;
  endtask

  task automatic ld_drive(input logic v, input logic [31:0] a, input logic [2:0] op);
    bus.ld_valid = v;
    bus.ld_addr  = a;
    bus.ld_op    = op;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b1;
    st_drive(1'b0, 32'd0, 32'd0, c_DM_W);
    ld_drive(1'b0, 32'd7, c_DM_H);

    // ---- Reset values
    tick();
    settle();
    check("rst_count",    32'(bus.count), 32'd0);
    check("rst_empty",    32'(bus.empty), 32'd1);
    check("rst_st_ready", 32'(bus.st_ready), 32'd1);
    check("rst_dm_we",    32'(bus.dm_we), 32'd0);
    check("rst_ld_stall", 32'(bus.ld_stall), 32'd0);
    check("rst_dm_a",     bus.dm_a, 32'd7);
    check("rst_dm_op",    32'(bus.dm_op), 32'(c_DM_H));
    tick();
    reset = 1'b0;

    // ---- Single store, then load it back
    st_drive(1'b1, 32'd12, 32'd998244353, c_DM_W);
    settle();
    check("t1_dm_we_pre", 32'(bus.dm_we), 32'd0);
    tick();
    st_drive(1'b0, 32'd0, 32'd0, c_DM_W);
    settle();
    check("t1_count1", 32'(bus.count), 32'd1);
    check("t1_dm_we",  32'(bus.dm_we), 32'd1);
    check("t1_dm_a",   bus.dm_a, 32'd12);
    check("t1_dm_wd",  bus.dm_wd, 32'd998244353);
    tick();
    ld_drive(1'b1, 32'd12, c_DM_W);
    settle();
    check("t1_count0", 32'(bus.count), 32'd0);
    check("t1_empty",  32'(bus.empty), 32'd1);
    check("t1_stall",  32'(bus.ld_stall), 32'd0);
    check("t1_ld_a",   bus.dm_a, 32'd12);
    check("t1_rdata",  dm_rd, 32'd998244353);

    // ---- Fill under a non-hitting load, refuse a 5th store, then drain
    ld_drive(1'b1, 32'd1020, c_DM_W);
    st_drive(1'b1, 32'd0, 32'd100, c_DM_W);
    settle();
    check("t2_we_0", 32'(bus.dm_we), 32'd0);
    tick();
    st_drive(1'b1, 32'd4, 32'd101, c_DM_W);
    settle();
    check("t2_we_1", 32'(bus.dm_we), 32'd0);
    check("t2_cnt_1", 32'(bus.count), 32'd1);
    tick();
    st_drive(1'b1, 32'd8, 32'd102, c_DM_W);
    settle();
    check("t2_cnt_2", 32'(bus.count), 32'd2);
    tick();
    st_drive(1'b1, 32'd16, 32'd103, c_DM_W);
    settle();
    check("t2_cnt_3", 32'(bus.count), 32'd3);
    check("t2_rdy_3", 32'(bus.st_ready), 32'd1);
    tick();
    st_drive(1'b1, 32'd20, 32'd104, c_DM_W);
    settle();
    check("t2_cnt_4",  32'(bus.count), 32'd4);
    check("t2_rdy_4",  32'(bus.st_ready), 32'd0);
    check("t2_we_4",   32'(bus.dm_we), 32'd0);
    check("t2_stall",  32'(bus.ld_stall), 32'd0);
    tick();
    settle();
    check("t2_refused", 32'(bus.count), 32'd4);
    ld_drive(1'b0, 32'd1020, c_DM_W);
    settle();
    check("t2_d0_we", 32'(bus.dm_we), 32'd1);
    check("t2_d0_a",  bus.dm_a, 32'd0);
    check("t2_d0_wd", bus.dm_wd, 32'd100);
    tick();
    settle();
    check("t2_d1_a",   bus.dm_a, 32'd4);
    check("t2_d1_cnt", 32'(bus.count), 32'd3);
    check("t2_d1_rdy", 32'(bus.st_ready), 32'd1);
    tick();
    st_drive(1'b0, 32'd0, 32'd0, c_DM_W);
    settle();
    check("t2_d2_a",   bus.dm_a, 32'd8);
    check("t2_d2_cnt", 32'(bus.count), 32'd3);
    tick();
    settle();
    check("t2_d3_a",   bus.dm_a, 32'd16);
    check("t2_d3_wd",  bus.dm_wd, 32'd103);
    tick();
    settle();
    check("t2_d4_a",   bus.dm_a, 32'd20);
    check("t2_d4_wd",  bus.dm_wd, 32'd104);
    tick();
    settle();
    check("t2_empty",  32'(bus.empty), 32'd1);
    check("t2_dm_we",  32'(bus.dm_we), 32'd0);

    // ---- Byte store at 13, load word 12 next cycle: one stall cycle
    st_drive(1'b1, 32'd13, 32'd88888, c_DM_B);
    tick();
    st_drive(1'b0, 32'd0, 32'd0, c_DM_W);
    ld_drive(1'b1, 32'd12, c_DM_W);
    settle();
    check("t3_stall", 32'(bus.ld_stall), 32'd1);
    check("t3_we",    32'(bus.dm_we), 32'd1);
    check("t3_a",     bus.dm_a, 32'd13);
    check("t3_op",    32'(bus.dm_op), 32'(c_DM_B));
    tick();
    settle();
    check("t3_release", 32'(bus.ld_stall), 32'd0);
    check("t3_ld_we",   32'(bus.dm_we), 32'd0);
    check("t3_rdata",   dm_rd, 32'h3B80_3801);

    // ---- Same-cycle store and load of halfword at 1022
    st_drive(1'b1, 32'd1022, 32'h0001_BEEF, c_DM_H);
    ld_drive(1'b1, 32'd1022, c_DM_H);
    settle();
    check("t4_stall0", 32'(bus.ld_stall), 32'd1);
    check("t4_we0",    32'(bus.dm_we), 32'd0);
    tick();
    st_drive(1'b0, 32'd0, 32'd0, c_DM_W);
    settle();
    check("t4_stall1", 32'(bus.ld_stall), 32'd1);
    check("t4_we1",    32'(bus.dm_we), 32'd1);
    check("t4_a1",     bus.dm_a, 32'd1022);
    check("t4_wd1",    bus.dm_wd, 32'h0001_BEEF);
    tick();
    settle();
    check("t4_release", 32'(bus.ld_stall), 32'd0);
    check("t4_op",      32'(bus.dm_op), 32'(c_DM_H));
    check("t4_rdata",   dm_rd, 32'hBEEF_0000);

    // ---- Steady push+drain at count 2 across pointer wrap
    ld_drive(1'b1, 32'd1020, c_DM_W);
    st_drive(1'b1, 32'd100, 32'd1100, c_DM_W);
    tick();
    st_drive(1'b1, 32'd104, 32'd1104, c_DM_W);
    tick();
    ld_drive(1'b0, 32'd1020, c_DM_W);
    for (int i = 0; i < 8; i++) begin
      st_drive(1'b1, 32'(108 + 4 * i), 32'(1108 + 4 * i), c_DM_W);
      settle();
      check($sformatf("t5_cnt_%0d", i), 32'(bus.count), 32'd2);
      check($sformatf("t5_a_%0d", i),   bus.dm_a, 32'(100 + 4 * i));
      check($sformatf("t5_wd_%0d", i),  bus.dm_wd, 32'(1100 + 4 * i));
      tick();
    end
    st_drive(1'b0, 32'd0, 32'd0, c_DM_W);
    settle();
    check("t5_tail_a0", bus.dm_a, 32'd132);
    tick();
    settle();
    check("t5_tail_a1", bus.dm_a, 32'd136);
    check("t5_tail_c1", 32'(bus.count), 32'd1);
    tick();
    settle();
    check("t5_empty", 32'(bus.empty), 32'd1);

    // ---- Asynchronous reset discards three pending stores
    ld_drive(1'b1, 32'd1020, c_DM_W);
    st_drive(1'b1, 32'd200, 32'hDEAD_0001, c_DM_W);
    tick();
    st_drive(1'b1, 32'd204, 32'hDEAD_0002, c_DM_W);
    tick();
    st_drive(1'b1, 32'd208, 32'hDEAD_0003, c_DM_W);
    tick();
    st_drive(1'b0, 32'd0, 32'd0, c_DM_W);
    settle();
    check("t6_cnt3", 32'(bus.count), 32'd3);
    #2;
    reset = 1'b1;
    ld_drive(1'b0, 32'd1020, c_DM_W);
    settle();
    check("t6_cnt0",  32'(bus.count), 32'd0);
    check("t6_empty", 32'(bus.empty), 32'd1);
    check("t6_we",    32'(bus.dm_we), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    settle();
    check("t6_mem200", mem[50], 32'd0);
    check("t6_mem204", mem[51], 32'd0);
    check("t6_mem208", mem[52], 32'd0);
    check("t6_idle_we", 32'(bus.dm_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
